// File: rtl/tnn_popcount_accum_act.sv
// rtl/tnn_popcount_accum_act.sv - ternary neuron popcount accumulator with threshold activation (optional TNN_ACC_SAT_EN)
module tnn_popcount_accum_act #(
    parameter int ACC_W = 10,
    parameter int TH_HI = 4,
    parameter int TH_LO = -4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4:0]              in_pc_pos,
    input  logic [4:0]              in_pc_neg,
    input  logic                    in_last,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [1:0]              out_trit,
    output logic signed [ACC_W-1:0] out_sum,
    output logic [7:0]              out_beats,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    localparam logic signed [ACC_W-1:0] TH_HI_W = ACC_W'(TH_HI);
    localparam logic signed [ACC_W-1:0] TH_LO_W = ACC_W'(TH_LO);

    state_t                  state;
    state_t                  state_next;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic [7:0]              beat_cnt;
    logic [7:0]              beat_cnt_inc;
    logic signed [5:0]       delta;
    logic [1:0]              trit_next;
    logic                    accept;
    logic                    done;

    assign in_ready  = (state != S_OUT);
    assign out_valid = (state == S_OUT);
    assign accept    = in_valid & in_ready;
    assign done      = out_valid & out_ready;

    // Six bits hold the full -31..+31 difference of two unclamped 5-bit counts.
    assign delta = $signed({1'b0, in_pc_pos}) - $signed({1'b0, in_pc_neg});

`ifdef TNN_ACC_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2 ** (ACC_W - 1)));

    logic signed [ACC_W:0] acc_wide;

    assign acc_wide = (ACC_W+1)'(acc) + (ACC_W+1)'(delta);

    always_comb begin
        acc_sum = acc_wide[ACC_W-1:0];
        if (acc_wide > SAT_MAX) begin
            acc_sum = SAT_MAX[ACC_W-1:0];
        end else if (acc_wide < SAT_MIN) begin
            acc_sum = SAT_MIN[ACC_W-1:0];
        end
    end
`else
    assign acc_sum = acc + ACC_W'(delta);
`endif

    assign beat_cnt_inc = (beat_cnt == 8'hFF) ? beat_cnt : 8'(beat_cnt + 8'd1);

    always_comb begin
        trit_next = 2'b00;
        if (acc_sum >= TH_HI_W) begin
            trit_next = 2'b01;
        end else if (acc_sum <= TH_LO_W) begin
            trit_next = 2'b11;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_ACC: begin
                if (accept) begin
                    state_next = in_last ? S_OUT : S_ACC;
                end
            end
            S_OUT: begin
                if (done) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Result registers hold after the handshake until the next evaluation overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            beat_cnt  <= '0;
            out_trit  <= 2'b00;
            out_sum   <= '0;
            out_beats <= '0;
        end else if (accept) begin
            acc      <= acc_sum;
            beat_cnt <= beat_cnt_inc;
            if (in_last) begin
                out_sum   <= acc_sum;
                out_trit  <= trit_next;
                out_beats <= beat_cnt_inc;
            end
        end else if (done) begin
            acc      <= '0;
            beat_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_tnn_popcount_accum_act.sv
// tb/tb_tnn_popcount_accum_act.sv - directed self-checking bench for tnn_popcount_accum_act
module tb_tnn_popcount_accum_act;

    logic              clk;
    logic              rst_n;
    logic [4:0]        in_pc_pos;
    logic [4:0]        in_pc_neg;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        out_trit;
    logic signed [9:0] out_sum;
    logic [7:0]        out_beats;
    logic              out_valid;
    logic              out_ready;

    logic [4:0]        n_pos;
    logic [4:0]        n_neg;
    logic              n_last;
    logic              n_valid;
    logic              n_in_ready;
    logic [1:0]        n_trit;
    logic signed [6:0] n_sum;
    logic [7:0]        n_beats;
    logic              n_out_valid;
    logic              n_out_ready;

    int vectors;
    int errors;

    tnn_popcount_accum_act dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pc_pos (in_pc_pos),
        .in_pc_neg (in_pc_neg),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_trit  (out_trit),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    tnn_popcount_accum_act #(.ACC_W(7)) dut7 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_pc_pos (n_pos),
        .in_pc_neg (n_neg),
        .in_last   (n_last),
        .in_valid  (n_valid),
        .in_ready  (n_in_ready),
        .out_trit  (n_trit),
        .out_sum   (n_sum),
        .out_beats (n_beats),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int pos, input int neg, input logic last);
        in_pc_pos = 5'(pos);
        in_pc_neg = 5'(neg);
        in_last   = last;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 10'sd0 || out_trit !== 2'b00 || out_beats !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b sum=%0d trit=%b beats=%0d want 0/0/00/0",
                     out_valid, out_sum, out_trit, out_beats);
        end
        rst_n = 1'b1;
        step();
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b want 1", in_ready);
        end
    endtask

    task automatic test_single_beat();
        send_beat(20, 3, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 10'sd17 || out_trit !== 2'b01 || out_beats !== 8'd1) begin
            errors++;
            $display("FAIL single_result: got valid=%0b sum=%0d trit=%b beats=%0d want 1/17/01/1",
                     out_valid, out_sum, out_trit, out_beats);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_in_ready_low: got %0b want 0", in_ready);
        end
        drain();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_release: got valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_multi_beat();
        send_beat(10, 12, 1'b0);
        send_beat(5, 5, 1'b0);
        send_beat(0, 2, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== -10'sd4 || out_trit !== 2'b11 || out_beats !== 8'd3) begin
            errors++;
            $display("FAIL multi_result: got valid=%0b sum=%0d trit=%b beats=%0d want 1/-4/11/3",
                     out_valid, out_sum, out_trit, out_beats);
        end
        drain();
    endtask

    task automatic test_hold();
        send_beat(7, 4, 1'b0);
        send_beat(2, 2, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 10'sd3 || out_trit !== 2'b00 || out_beats !== 8'd2) begin
            errors++;
            $display("FAIL hold_result: got valid=%0b sum=%0d trit=%b beats=%0d want 1/3/00/2",
                     out_valid, out_sum, out_trit, out_beats);
        end
        in_pc_pos = 5'd31;
        in_pc_neg = 5'd0;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 10'sd3 ||
                out_trit !== 2'b00 || out_beats !== 8'd2) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got valid=%0b rdy=%0b sum=%0d trit=%b beats=%0d want 1/0/3/00/2",
                         i, out_valid, in_ready, out_sum, out_trit, out_beats);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain();
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got rdy=%0b valid=%0b want 1/0", in_ready, out_valid);
        end
        send_beat(1, 0, 1'b1);
        vectors++;
        if (out_sum !== 10'sd1 || out_beats !== 8'd1 || out_trit !== 2'b00) begin
            errors++;
            $display("FAIL hold_restart: got sum=%0d beats=%0d trit=%b want 1/1/00", out_sum, out_beats, out_trit);
        end
        drain();
    endtask

    task automatic test_overflow();
        n_pos   = 5'd31;
        n_neg   = 5'd0;
        n_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_last = (i == 4);
            step();
        end
        n_valid = 1'b0;
        n_last  = 1'b0;
        vectors++;
`ifdef TNN_ACC_SAT_EN
        if (n_out_valid !== 1'b1 || n_sum !== 7'sd63 || n_trit !== 2'b01 || n_beats !== 8'd5) begin
            errors++;
            $display("FAIL overflow_sat: got valid=%0b sum=%0d trit=%b beats=%0d want 1/63/01/5",
                     n_out_valid, n_sum, n_trit, n_beats);
        end
`else
        if (n_out_valid !== 1'b1 || n_sum !== 7'sd27 || n_trit !== 2'b01 || n_beats !== 8'd5) begin
            errors++;
            $display("FAIL overflow_wrap: got valid=%0b sum=%0d trit=%b beats=%0d want 1/27/01/5",
                     n_out_valid, n_sum, n_trit, n_beats);
        end
`endif
        n_out_ready = 1'b1;
        step();
        n_out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        send_beat(5, 0, 1'b0);
        send_beat(5, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 10'sd0 || out_beats !== 8'd0 ||
            out_trit !== 2'b00 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got valid=%0b sum=%0d beats=%0d trit=%b rdy=%0b want 0/0/0/00/1",
                     out_valid, out_sum, out_beats, out_trit, in_ready);
        end
        step();
        rst_n = 1'b1;
        step();
        send_beat(1, 0, 1'b1);
        vectors++;
        if (out_valid !== 1'b1 || out_sum !== 10'sd1 || out_beats !== 8'd1) begin
            errors++;
            $display("FAIL async_restart: got valid=%0b sum=%0d beats=%0d want 1/1/1", out_valid, out_sum, out_beats);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int b_pos  [4] = '{3, 2, 0, 4};
        int b_neg  [4] = '{0, 0, 6, 4};
        logic b_last [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        int e_sum  [3] = '{5, -6, 0};
        logic [1:0] e_trit [3] = '{2'b01, 2'b11, 2'b00};
        int e_beats [3] = '{2, 1, 1};
        int idx;
        int res;
        int gaps;
        logic rdy;
        idx  = 0;
        res  = 0;
        gaps = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && res < 3; cyc++) begin
            if (out_valid) begin
                vectors++;
                if (out_sum !== 10'(e_sum[res]) || out_trit !== e_trit[res] || out_beats !== 8'(e_beats[res])) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got sum=%0d trit=%b beats=%0d want %0d/%b/%0d",
                             res, out_sum, out_trit, out_beats, e_sum[res], e_trit[res], e_beats[res]);
                end
                res++;
            end
            if (!in_ready) gaps++;
            if (idx < 4) begin
                in_pc_pos = 5'(b_pos[idx]);
                in_pc_neg = 5'(b_neg[idx]);
                in_last   = b_last[idx];
                in_valid  = 1'b1;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            rdy = in_ready;
            step();
            if (in_valid && rdy) idx++;
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        vectors++;
        if (res !== 3 || idx !== 4) begin
            errors++;
            $display("FAIL b2b_timeout: got results=%0d beats_taken=%0d want 3/4", res, idx);
        end
        vectors++;
        if (gaps !== 3) begin
            errors++;
            $display("FAIL b2b_gaps: got %0d in_ready-low cycles want 3", gaps);
        end
    endtask

    initial begin
        vectors     = 0;
        errors      = 0;
        rst_n       = 1'b0;
        in_pc_pos   = '0;
        in_pc_neg   = '0;
        in_last     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        n_pos       = '0;
        n_neg       = '0;
        n_last      = 1'b0;
        n_valid     = 1'b0;
        n_out_ready = 1'b0;
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_hold();
        test_overflow();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
